// File: rtl/nanoV_pkg.sv
// Shared definitions for the nanoV serial datapath: default sizes, the slice-index type
// and a legality check for the slice width.
package nanoV_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 16;
  localparam int SLICE_DEF = 1;

  typedef logic [$clog2(XLEN_DEF / SLICE_DEF)-1:0] slice_idx_t;

  function automatic bit slice_w_legal(input int xlen, input int slice);
    return ((slice == 1) || (slice == 2) || (slice == 4) || (slice == 8)) &&
           ((xlen % slice) == 0);
  endfunction

endpackage

// File: rtl/serial_regfile_seq.sv
// Slice sequencing for the serial register file: read/write slice counters, the
// write-side hold that keeps the write side one slice behind, restart, and last-slice.
module serial_regfile_seq
  import nanoV_pkg::*;
#(
  parameter int NSL = 32,
  parameter int CW  = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pause,
  input  logic          restart,
  output logic [CW-1:0] rd_idx,
  output logic [CW-1:0] wr_idx,
  output logic          last_slice
);

  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_hold_q, wr_hold_d;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] idx);
    return (idx == CW'(NSL - 1)) ? '0 : idx + CW'(1);
  endfunction

  // wr_hold lags pause by one cycle, so the write side catches up while paused
  // and re-opens the one-slice gap on release.
  always_comb begin
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    wr_hold_d = pause;
    if (restart) begin
      rd_idx_d  = '0;
      wr_idx_d  = '0;
      wr_hold_d = 1'b1;
    end else begin
      if (!pause)     rd_idx_d = wrap_inc(rd_idx_q);
      if (!wr_hold_q) wr_idx_d = wrap_inc(wr_idx_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      wr_hold_q <= 1'b1;
    end else begin
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      wr_hold_q <= wr_hold_d;
    end
  end

  assign rd_idx     = rd_idx_q;
  assign wr_idx     = wr_idx_q;
  assign last_slice = (wr_idx_q == CW'(NSL - 1)) && !wr_hold_q;

endmodule

// File: rtl/serial_regfile.sv
// Slice-serial register file for nanoV: streams one slice of rs1/rs2 per clock and
// absorbs one slice of the result, with write-to-read bypass when the counters coincide.
module serial_regfile
  import nanoV_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int SLICE = SLICE_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS),
  localparam int NSL   = XLEN / SLICE,
  localparam int CW    = (NSL > 1) ? $clog2(NSL) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pause,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic [SLICE-1:0] data_rd,
  output logic [SLICE-1:0] data_rs1,
  output logic [SLICE-1:0] data_rs2,
  output logic [CW-1:0]    wr_slice,
  output logic             last_slice
);

  if (!slice_w_legal(XLEN, SLICE)) begin : g_bad_slice
    $error("serial_regfile: SLICE must be 1, 2, 4 or 8 and divide XLEN");
  end

  logic [CW-1:0]    rd_idx, wr_idx;
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [SLICE-1:0] data_rs1_q, data_rs1_d;
  logic [SLICE-1:0] data_rs2_q, data_rs2_d;
  logic             wr_act, same_idx;

  serial_regfile_seq #(
    .NSL (NSL),
    .CW  (CW)
  ) u_seq (
    .clk        (clk),
    .rstn       (rstn),
    .pause      (pause),
    .restart    (restart),
    .rd_idx     (rd_idx),
    .wr_idx     (wr_idx),
    .last_slice (last_slice)
  );

  assign wr_act   = wr_en && (rd != '0);
  assign same_idx = (wr_idx == rd_idx);

  // Storage is deliberately unreset; x0 has no backing row.
  always_ff @(posedge clk) begin
    if (wr_act) regs_q[rd][int'(wr_idx)*SLICE +: SLICE] <= data_rd;
  end

  always_comb begin
    data_rs1_d = '0;
    data_rs2_d = '0;
    if (rs1 != '0) begin
      if (wr_act && (rd == rs1) && same_idx) data_rs1_d = data_rd;
      else                                   data_rs1_d = regs_q[rs1][int'(rd_idx)*SLICE +: SLICE];
    end
    if (rs2 != '0) begin
      if (wr_act && (rd == rs2) && same_idx) data_rs2_d = data_rd;
      else                                   data_rs2_d = regs_q[rs2][int'(rd_idx)*SLICE +: SLICE];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_rs1_q <= '0;
      data_rs2_q <= '0;
    end else begin
      data_rs1_q <= data_rs1_d;
      data_rs2_q <= data_rs2_d;
    end
  end

  assign data_rs1 = data_rs1_q;
  assign data_rs2 = data_rs2_q;
  assign wr_slice = wr_idx;

endmodule
